alu_rr_arbiter: RTL and testbench
=================================

Name: alu_rr_arbiter

Overview:
- Shares one hierarchical ALU (arithmetic, logic, compare and shift units, each with a registered output) between two requesters.
- Accepts operation requests on valid/ready, arbitrates round-robin, and drives the unit operands, ALU_FUN and the one-hot unit enable for one cycle.
- Captures the unit result and returns it on a valid/ready response channel, tagged with the requester id.
- Sits between the two command sources and the ALU top level.

Parameters:
- WIDTH, 16, operand and result width in bits.

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_a  input  WIDTH  requester 0 operand A
- req0_b  input  WIDTH  requester 0 operand B
- req0_fun  input  4  requester 0 function; [3:2] selects the unit, [1:0] is the unit ALU_FUN
- req1_valid, req1_ready, req1_a, req1_b, req1_fun  same as requester 0, for requester 1
- alu_a  output  WIDTH  operand A to all units
- alu_b  output  WIDTH  operand B to all units
- alu_fun  output  2  ALU_FUN to all units
- arith_en, logic_en, cmp_en, shift_en  output  1 each  unit enables, at most one high
- alu_res_in  input  WIDTH  OR of the unit data outputs; compare output zero-extended
- alu_flag_in  input  1  OR of the unit flags
- rsp_valid  output  1  response available
- rsp_ready  input  1  response consumer ready
- rsp_id  output  1  requester id of the response
- rsp_data  output  WIDTH  captured result
- rsp_flag  output  1  captured flag

Interface: one clock domain (clk). reset_n is asynchronous and active-low.

Behaviour:
- State machine states: IDLE, ISSUE, CAPTURE, RESPOND.
- Reset values:
  - state IDLE, rr_ptr 0.
  - All registered outputs 0: alu_a, alu_b, alu_fun, all enables, rsp_valid, rsp_id, rsp_data, rsp_flag.
  - Any operation in flight is dropped and never reported.
- Grant, combinational, in IDLE only:
  - Only one valid: grant that requester.
  - Both valid: grant rr_ptr.
  - reqN_ready = (state==IDLE) & reqN_valid & grant==N. The ready signals are never both high. Both are 0 outside IDLE.
- IDLE to ISSUE on the accepting handshake edge:
  - Latch a/b to alu_a/alu_b, fun[1:0] to alu_fun, and the granted id.
  - Set the enable decoded from fun[3:2]: 00 arith, 01 logic, 10 cmp, 11 shift.
- ISSUE:
  - Exactly one enable high for this single cycle; the units register at the end of it.
  - Move to CAPTURE. Enables return to 0. alu_a, alu_b and alu_fun stay held.
- CAPTURE:
  - alu_res_in and alu_flag_in are valid during this cycle.
  - At the edge, register them into rsp_data/rsp_flag, set rsp_valid=1 and rsp_id, then go to RESPOND.
- RESPOND:
  - rsp_valid, rsp_id, rsp_data and rsp_flag are held stable until rsp_valid & rsp_ready.
  - On that edge: rsp_valid<=0, rr_ptr <= ~rsp_id, go to IDLE.
- Latency: handshake edge to rsp_valid high is 2 clock edges. Minimum issue interval is 4 cycles when rsp_ready is held high.
- No new request is accepted while an operation is outstanding. Requesters hold valid and payload until ready.
- A compare with fun[1:0]=00 is forwarded as-is; the response then carries data 0 and flag 0.
- Fairness: with both requesters continuously valid, grants strictly alternate.
- reset_n asserted in any state returns to IDLE with all reset values within the same cycle, asynchronously.

Test Plan:
- Reset, then req0 with a=5, b=5, fun=4'b1001 (cmp equal) -> cmp_en high exactly 1 cycle with alu_fun=01; rsp_valid 2 edges after accept, rsp_id=0, rsp_data=1, rsp_flag=1.
- req0 and req1 both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1 starting with 0; each grant is 4 cycles apart.
- req1 with fun=4'b1011, a=3, b=7 (cmp less) and rsp_ready held 0 for 5 cycles -> rsp_data=3 and rsp_flag=1 stay stable; req0_ready stays 0 throughout; after rsp_ready, IDLE and the next grant goes to req0.
- Unit decode sweep: fun[3:2]=00, 01, 10, 11 -> arith_en, logic_en, cmp_en, shift_en each pulse alone; the others stay 0.
- reset_n pulsed low during CAPTURE -> all outputs 0 immediately; no rsp_valid for the dropped operation; the next request is served normally with rr_ptr=0.
- Only req1 valid while rr_ptr=0 -> req1 granted immediately; no idle wait.

Source files
------------

// File: rtl/alu_rr_arbiter.sv
// Round-robin front end that shares one hierarchical ALU between two
// requesters. Each accepted operation drives the unit operands for one
// enable cycle, captures the registered unit result and returns it on a
// valid/ready response channel tagged with the requester id.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a request; grant is evaluated combinationally
// ISSUE   | one unit enable high; the unit registers at the end of it
// CAPTURE | unit result/flag valid on alu_res_in/alu_flag_in
// RESPOND | response held on rsp_* until rsp_ready

module alu_rr_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_fun,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_fun,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_fun,
    output logic             arith_en,
    output logic             logic_en,
    output logic             cmp_en,
    output logic             shift_en,
    input  logic [WIDTH-1:0] alu_res_in,
    input  logic             alu_flag_in,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_flag
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESPOND = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             rr_ptr;
    logic             cur_id;
    logic             grant_id;
    logic             in_idle;
    logic             accept;
    logic             rsp_fire;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [3:0]       sel_fun;

    // Grant: a lone requester wins outright, contention is settled by rr_ptr.
    always_comb begin
        grant_id = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = rr_ptr;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
    end

    assign in_idle    = (state == IDLE);
    assign req0_ready = in_idle & req0_valid & ~grant_id;
    assign req1_ready = in_idle & req1_valid &  grant_id;
    assign accept     = req0_ready | req1_ready;
    assign rsp_fire   = rsp_valid & rsp_ready;

    // Payload mux for the granted requester.
    always_comb begin
        sel_a   = req0_a;
        sel_b   = req0_b;
        sel_fun = req0_fun;
        if (grant_id) begin
            sel_a   = req1_a;
            sel_b   = req1_b;
            sel_fun = req1_fun;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE:   state_nxt = CAPTURE;
            CAPTURE: state_nxt = RESPOND;
            RESPOND: if (rsp_fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand/enable issue, result capture and round-robin update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr    <= 1'b0;
            cur_id    <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_fun   <= '0;
            arith_en  <= 1'b0;
            logic_en  <= 1'b0;
            cmp_en    <= 1'b0;
            shift_en  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_flag  <= 1'b0;
        end else begin
            // Enables are a single-cycle pulse; only the accept edge raises one.
            arith_en <= 1'b0;
            logic_en <= 1'b0;
            cmp_en   <= 1'b0;
            shift_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_a   <= sel_a;
                        alu_b   <= sel_b;
                        alu_fun <= sel_fun[1:0];
                        cur_id  <= grant_id;
                        case (sel_fun[3:2])
                            2'b00:   arith_en <= 1'b1;
                            2'b01:   logic_en <= 1'b1;
                            2'b10:   cmp_en   <= 1'b1;
                            default: shift_en <= 1'b1;
                        endcase
                    end
                end
                CAPTURE: begin
                    rsp_data  <= alu_res_in;
                    rsp_flag  <= alu_flag_in;
                    rsp_id    <= cur_id;
                    rsp_valid <= 1'b1;
                end
                RESPOND: begin
                    if (rsp_fire) begin
                        rsp_valid <= 1'b0;
                        rr_ptr    <= ~rsp_id;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Bench for alu_rr_arbiter: a behavioural ALU model answers the enables,
// directed operations push hand-computed responses into a queue and a
// monitor pops and compares them on every response handshake.

module tb_alu_rr_arbiter;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         req0_valid, req0_ready;
    logic [W-1:0] req0_a, req0_b;
    logic [3:0]   req0_fun;
    logic         req1_valid, req1_ready;
    logic [W-1:0] req1_a, req1_b;
    logic [3:0]   req1_fun;
    logic [W-1:0] alu_a, alu_b;
    logic [1:0]   alu_fun;
    logic         arith_en, logic_en, cmp_en, shift_en;
    logic [W-1:0] alu_res_in;
    logic         alu_flag_in;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_flag;
    logic [W-1:0] rsp_data;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [W+1:0] exp_q[$];   // {id, flag, data}

    always #5 clk = ~clk;

    alu_rr_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_fun(req0_fun),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_fun(req1_fun),
        .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun),
        .arith_en(arith_en), .logic_en(logic_en), .cmp_en(cmp_en), .shift_en(shift_en),
        .alu_res_in(alu_res_in), .alu_flag_in(alu_flag_in),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_flag(rsp_flag)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // ALU model: each unit drives zero unless enabled in the previous cycle;
    // compare returns its condition code zero-extended when the test holds.
    function automatic logic [W:0] alu_calc(input logic [3:0] en, input logic [1:0] f,
                                            input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0]   r;
        logic [W:0]   t;
        logic [W-1:0] l;
        logic [W-1:0] s;
        logic         c;
        r = '0;
        if (en[0]) begin
            case (f)
                2'b00:   t = {1'b0, a} + {1'b0, b};
                2'b01:   t = {1'b0, a} - {1'b0, b};
                2'b10:   t = {1'b0, a} + (W+1)'(1);
                default: t = {1'b0, a} - (W+1)'(1);
            endcase
            r = r | t;
        end
        if (en[1]) begin
            case (f)
                2'b00:   l = a & b;
                2'b01:   l = a | b;
                2'b10:   l = a ^ b;
                default: l = ~a;
            endcase
            r = r | {(l == '0), l};
        end
        if (en[2]) begin
            case (f)
                2'b01:   c = (a == b);
                2'b10:   c = (a > b);
                2'b11:   c = (a < b);
                default: c = 1'b0;
            endcase
            if (c) r = r | {1'b1, {(W-2){1'b0}}, f};
        end
        if (en[3]) begin
            case (f)
                2'b00:   s = a << b[3:0];
                2'b01:   s = a >> b[3:0];
                2'b10:   s = $unsigned($signed(a) >>> b[3:0]);
                default: s = (a << b[3:0]) | (a >> (W - int'(b[3:0])));
            endcase
            r = r | {1'b0, s};
        end
        return r;
    endfunction

    logic [W-1:0] res_q  = '0;
    logic         flag_q = 1'b0;
    assign alu_res_in  = res_q;
    assign alu_flag_in = flag_q;

    // Unit output registers.
    always @(posedge clk) begin
        {flag_q, res_q} <= alu_calc({shift_en, cmp_en, logic_en, arith_en}, alu_fun, alu_a, alu_b);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: ready exclusivity every cycle, scoreboard pop on each response.
    always @(negedge clk) begin
        logic [W+1:0] item;
        if (reset_n) begin
            check("ready_exclusive", {31'd0, req0_ready & req1_ready}, 32'd0);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got id=%0d data=0x%0h with no operation outstanding",
                             rsp_id, rsp_data);
                end else begin
                    item = exp_q.pop_front();
                    check("rsp_id",   {31'd0, rsp_id},   {31'd0, item[W+1]});
                    check("rsp_data", {16'd0, rsp_data}, {16'd0, item[W-1:0]});
                    check("rsp_flag", {31'd0, rsp_flag}, {31'd0, item[W]});
                end
            end
        end
    end

    task automatic drive(input logic id, input logic v, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [3:0] f);
        if (id) begin
            req1_valid = v; req1_a = a; req1_b = b; req1_fun = f;
        end else begin
            req0_valid = v; req0_a = a; req0_b = b; req0_fun = f;
        end
    endtask

    // sel: 0 = req0_ready, 1 = req1_ready, 2 = either.
    task automatic wait_grant(input int sel, output bit ok, output int n);
        n = 0;
        while (!((sel == 0 && req0_ready) || (sel == 1 && req1_ready) ||
                 (sel == 2 && (req0_ready || req1_ready))) && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        ok = (n < 50);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout: no ready for selector %0d within 50 cycles", sel);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain", exp_q.size(), 32'd0);
    endtask

    // One complete operation from a single requester with rsp_ready high.
    task automatic do_op(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [3:0] fun, input logic [W-1:0] exp_d, input logic exp_f,
                         input bit want_immediate);
        bit ok;
        int n;
        @(negedge clk);
        drive(id, 1'b1, a, b, fun);
        #1;
        wait_grant(id ? 1 : 0, ok, n);
        if (!ok) begin
            drive(id, 1'b0, a, b, fun);
            return;
        end
        if (want_immediate) check("immediate_grant", n, 32'd0);
        exp_q.push_back({id, exp_f, exp_d});
        @(posedge clk); #1;
        drive(id, 1'b0, a, b, fun);
        check("unit_en", {28'd0, shift_en, cmp_en, logic_en, arith_en}, 32'd1 << fun[3:2]);
        check("alu_fun", {30'd0, alu_fun}, {30'd0, fun[1:0]});
        check("alu_ab", {alu_a, alu_b}, {a, b});
        @(posedge clk); #1;
        check("en_one_cycle", {28'd0, shift_en, cmp_en, logic_en, arith_en}, 32'd0);
        check("rsp_valid_early", {31'd0, rsp_valid}, 32'd0);
        check("alu_hold", {alu_a, alu_b}, {a, b});
        @(posedge clk); #1;
        check("latency_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        @(posedge clk); #1;
        check("rsp_valid_cleared", {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit           ok;
        int           n;
        int           last;
        logic         got;
        logic [3:0]   exp_order;

        reset_n   = 1'b0;
        rsp_ready = 1'b1;
        drive(1'b0, 1'b0, '0, '0, 4'h0);
        drive(1'b1, 1'b0, '0, '0, 4'h0);
        repeat (3) @(negedge clk);
        check("reset_ab", {alu_a, alu_b}, 32'd0);
        check("reset_ctl", {7'd0, alu_fun, shift_en, cmp_en, logic_en, arith_en,
                            rsp_valid, rsp_id, rsp_flag, rsp_data}, 32'd0);
        reset_n = 1'b1;

        // Only req1 valid with rr_ptr=0: granted at once. 3+4=7.
        do_op(1'b1, 16'd3, 16'd4, 4'b0000, 16'd7, 1'b0, 1'b1);
        // Compare equal 5,5 -> data 1, flag 1.
        do_op(1'b0, 16'd5, 16'd5, 4'b1001, 16'd1, 1'b1, 1'b1);
        drain();

        // Compare less 3<7 held for 5 cycles with rsp_ready low.
        @(negedge clk);
        rsp_ready = 1'b0;
        drive(1'b1, 1'b1, 16'd3, 16'd7, 4'b1011);
        #1;
        wait_grant(1, ok, n);
        if (ok) begin
            exp_q.push_back({1'b1, 1'b1, 16'd3});
            @(posedge clk); #1;
            req1_valid = 1'b0;
            drive(1'b0, 1'b1, 16'd10, 16'd3, 4'b0000);
            @(posedge clk); #1;
            check("hold_req0_ready_capture", {31'd0, req0_ready}, 32'd0);
            @(posedge clk); #1;
            repeat (5) begin
                check("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
                check("hold_rsp_data", {16'd0, rsp_data}, 32'd3);
                check("hold_rsp_flag", {31'd0, rsp_flag}, 32'd1);
                check("hold_rsp_id", {31'd0, rsp_id}, 32'd1);
                check("hold_req0_ready", {31'd0, req0_ready}, 32'd0);
                @(posedge clk); #1;
            end
        end
        rsp_ready = 1'b1;
        drive(1'b1, 1'b1, 16'd10, 16'd3, 4'b0101);

        // Both continuously valid: 0,1,0,1, four cycles apart.
        // req0 add 10+3=13; req1 or 10|3=11.
        exp_order = 4'b1010;
        last      = 0;
        for (int k = 0; k < 4; k++) begin
            wait_grant(2, ok, n);
            if (!ok) break;
            got = req1_ready;
            check("grant_order", {31'd0, got}, {31'd0, exp_order[k]});
            if (k > 0) check("grant_interval", cyc - last, 32'd4);
            last = cyc;
            exp_q.push_back(exp_order[k] ? {1'b1, 1'b0, 16'd11} : {1'b0, 1'b0, 16'd13});
            @(posedge clk); #1;
            if (k == 3) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain();

        // Unit decode sweep.
        do_op(1'b1, 16'd3,    16'd5,    4'b0001, 16'hFFFE, 1'b1, 1'b1);
        do_op(1'b0, 16'h00F0, 16'h00FF, 4'b0110, 16'h000F, 1'b0, 1'b1);
        do_op(1'b1, 16'd9,    16'd9,    4'b1000, 16'h0000, 1'b0, 1'b1);
        do_op(1'b0, 16'h0003, 16'd4,    4'b1100, 16'h0030, 1'b0, 1'b1);
        drain();

        // Reset during CAPTURE drops the operation and clears rr_ptr.
        @(negedge clk);
        drive(1'b0, 1'b1, 16'd1, 16'd1, 4'b0000);
        #1;
        wait_grant(0, ok, n);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(posedge clk); #1;
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_ab", {alu_a, alu_b}, 32'd0);
        check("async_reset_ctl", {7'd0, alu_fun, shift_en, cmp_en, logic_en, arith_en,
                                  rsp_valid, rsp_id, rsp_flag, rsp_data}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) begin
            @(negedge clk); #1;
            check("no_dropped_rsp", {31'd0, rsp_valid}, 32'd0);
        end

        // Both valid after reset: req0 first. AND 0x00FF&0x0F0F=0x000F; NOT 0=0xFFFF.
        drive(1'b0, 1'b1, 16'h00FF, 16'h0F0F, 4'b0100);
        drive(1'b1, 1'b1, 16'h0000, 16'h0000, 4'b0111);
        #1;
        wait_grant(2, ok, n);
        if (ok) begin
            check("post_reset_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
            exp_q.push_back({1'b0, 1'b0, 16'h000F});
            @(posedge clk); #1;
            req0_valid = 1'b0;
            wait_grant(1, ok, n);
            if (ok) begin
                exp_q.push_back({1'b1, 1'b0, 16'hFFFF});
                @(posedge clk); #1;
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain();

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
